// File: rtl/fifo_cdc_pkg.sv
// Gray-code helpers shared by the write-side and read-side CDC FIFO controllers.
// They work on a 32-bit word so that one package serves any pointer width up to 32 bits.
package fifo_cdc_pkg;

  localparam int unsigned PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended inputs decode correctly because the extra leading zeros add nothing to the XOR chain.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin = gray;
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
// The read-side controller reuses this block.
module sync2 #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);

  logic [width_p-1:0] r_meta;
  logic [width_p-1:0] r_sync;

  // NOTE: non-blocking assignments let r_sync take the old r_meta, so the data passes through two real stages.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/fifo_cdc_wr_ctrl.sv
// Write-domain controller of an async FIFO. It owns the write pointer, the registered full flag and the
// conservative occupancy count. Data goes straight through to an external async-read RAM.
module fifo_cdc_wr_ctrl
  import fifo_cdc_pkg::*;
#(
  parameter  int width_p = 8,
  parameter  int depth_p = 8,
  localparam int AW      = $clog2(depth_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               wr_valid_o,
  output logic [AW-1:0]      wr_addr_o,
  output logic [width_p-1:0] wr_data_o,
  output logic [AW:0]        wptr_gray_o,
  input  logic [AW:0]        rptr_gray_i,
  output logic               full_o,
  output logic [AW:0]        wr_count_o
);

  localparam int PW = AW + 1;

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wptr_gray;
  logic          r_full;

  logic          w_push;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rsync;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_full_match;
  ptr_word_t     w_wgray_word;
  ptr_word_t     w_rbin_word;
  logic          w_unused_hi;

  assign ready_o     = ~r_full & ~reset_i;
  assign w_push      = valid_i & ready_o;
  assign w_wbin_next = r_wbin + PW'(w_push);

  assign w_wgray_word = bin2gray(ptr_word_t'(w_wbin_next));
  assign w_wgray_next = w_wgray_word[PW-1:0];

  sync2 #(.width_p(PW)) u_rptr_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (rptr_gray_i),
    .q_o     (w_rsync)
  );

  assign w_rbin_word = gray2bin(ptr_word_t'(w_rsync));
  assign w_rbin      = w_rbin_word[PW-1:0];
  assign w_unused_hi = ^{w_wgray_word[PTR_MAX_W-1:PW], w_rbin_word[PTR_MAX_W-1:PW]};

  // Full means the write pointer is exactly one lap ahead: in Gray code the top two bits differ, the rest match.
  generate
    if (AW == 1) begin : g_full_aw1
      assign w_full_match = ~w_rsync;
    end else begin : g_full_awn
      assign w_full_match = {~w_rsync[AW:AW-1], w_rsync[AW-2:0]};
    end
  endgenerate

  // NOTE: the Gray pointer is registered from the next binary value so it changes at most one bit per edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wbin      <= '0;
      r_wptr_gray <= '0;
      r_full      <= 1'b0;
    end else begin
      r_wbin      <= w_wbin_next;
      r_wptr_gray <= w_wgray_next;
      r_full      <= (w_wgray_next == w_full_match);
    end
  end

  assign wr_valid_o  = w_push;
  assign wr_data_o   = data_i;
  assign wr_addr_o   = r_wbin[AW-1:0];
  assign wptr_gray_o = r_wptr_gray;
  assign full_o      = r_full;
  assign wr_count_o  = r_wbin - w_rbin;

endmodule

// File: tb/tb_fifo_cdc_wr_ctrl.sv
// Scenario bench for fifo_cdc_wr_ctrl: scoreboard of expected RAM writes plus a pointer-arithmetic model of full/count.
module tb_fifo_cdc_wr_ctrl;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          valid_i;
  logic [W-1:0]  data_i;
  logic          ready_o;
  logic          wr_valid_o;
  logic [AW-1:0] wr_addr_o;
  logic [W-1:0]  wr_data_o;
  logic [PW-1:0] wptr_gray_o;
  logic [PW-1:0] rptr_gray_i;
  logic          full_o;
  logic [PW-1:0] wr_count_o;

  fifo_cdc_wr_ctrl #(.width_p(W), .depth_p(D)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .wr_valid_o  (wr_valid_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .wptr_gray_o (wptr_gray_o),
    .rptr_gray_i (rptr_gray_i),
    .full_o      (full_o),
    .wr_count_o  (wr_count_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Bench model: binary write pointer, two-stage copy of the read pointer, full flag.
  logic [PW-1:0]   m_wbin   = '0;
  logic [PW-1:0]   m_s1     = '0;
  logic [PW-1:0]   m_s2     = '0;
  logic            m_full   = 1'b0;
  logic            m_exp_push = 1'b0;
  logic [PW-1:0]   rd_bin   = '0;
  logic [AW+W-1:0] sb_q[$];

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [PW-1:0] m_count();
    return m_wbin - g2b(m_s2);
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] d);
    valid_i     = v;
    data_i      = d;
    rptr_gray_i = b2g(rd_bin);
  endtask

  // Called just after a rising edge: scoreboard checks mid-cycle, then one edge and the model update.
  task automatic tick();
    logic [AW+W-1:0] exp_wr;
    logic [PW-1:0]   nb;
    #4;
    m_exp_push = valid_i & ~m_full & ~reset_i;
    if (!reset_i) begin
      if (m_exp_push) sb_q.push_back({m_wbin[AW-1:0], data_i});
      n_vec++;
      if (wr_valid_o !== m_exp_push) begin
        n_err++;
        $display("FAIL wr_valid: got %b want %b", wr_valid_o, m_exp_push);
      end
      if (wr_valid_o === 1'b1) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_write: got addr %0d data %h, want no write", wr_addr_o, wr_data_o);
        end else begin
          exp_wr = sb_q.pop_front();
          if ({wr_addr_o, wr_data_o} !== exp_wr) begin
            n_err++;
            $display("FAIL sb_write: got addr %0d data %h, want addr %0d data %h",
                     wr_addr_o, wr_data_o, exp_wr[AW+W-1:W], exp_wr[W-1:0]);
          end
        end
        if (full_o === 1'b1) begin
          n_err++;
          $display("FAIL write_while_full: got write with full_o=1, want none");
        end
      end
      n_vec++;
      if (full_o !== m_full) begin
        n_err++;
        $display("FAIL full: got %b want %b", full_o, m_full);
      end
      n_vec++;
      if (wr_count_o !== m_count()) begin
        n_err++;
        $display("FAIL wr_count: got %0d want %0d", wr_count_o, m_count());
      end
      n_vec++;
      if (ready_o !== ~m_full) begin
        n_err++;
        $display("FAIL ready: got %b want %b", ready_o, ~m_full);
      end
      n_vec++;
      if (wr_count_o > 4'd8) begin
        n_err++;
        $display("FAIL count_bound: got %0d want <= 8", wr_count_o);
      end
    end
    @(posedge clk);
    if (reset_i) begin
      m_wbin = '0;
      m_s1   = '0;
      m_s2   = '0;
      m_full = 1'b0;
      sb_q.delete();
    end else begin
      nb     = m_wbin + PW'(m_exp_push);
      m_full = ((nb - g2b(m_s2)) == 4'd8);
      m_wbin = nb;
      m_s2   = m_s1;
      m_s1   = rptr_gray_i;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    rd_bin  = '0;
    drive(1'b1, 8'h11);
    #1 reset_i = 1'b1;
    #1;
    n_vec++;
    if ({ready_o, wr_valid_o, full_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ctrl: got ready/wr_valid/full %b%b%b want 000", ready_o, wr_valid_o, full_o);
    end
    n_vec++;
    if ({wptr_gray_o, wr_count_o} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ptr: got gray %h count %0d want 0 0", wptr_gray_o, wr_count_o);
    end
    @(posedge clk);
    #1;
    tick();
    reset_i = 1'b0;
    drive(1'b0, 8'h00);
    #1;
    n_vec++;
    if ({ready_o, full_o, wptr_gray_o, wr_count_o} !== {1'b1, 1'b0, 4'h0, 4'h0}) begin
      n_err++;
      $display("FAIL post_reset: got ready %b full %b gray %h count %0d want 1 0 0 0",
               ready_o, full_o, wptr_gray_o, wr_count_o);
    end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'hA0 + 8'(i));
      #1;
      n_vec++;
      if (wr_addr_o !== 3'(i)) begin
        n_err++;
        $display("FAIL fill_addr: got %0d want %0d", wr_addr_o, i);
      end
      tick();
    end
    n_vec++;
    if ({full_o, ready_o, wr_count_o} !== {1'b1, 1'b0, 4'd8}) begin
      n_err++;
      $display("FAIL fill_full: got full %b ready %b count %0d want 1 0 8", full_o, ready_o, wr_count_o);
    end
    drive(1'b1, 8'hEE);
    #1;
    n_vec++;
    if (wr_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL fill_blocked: got wr_valid %b want 0", wr_valid_o);
    end
    tick();
  endtask

  task automatic test_release();
    rd_bin = 4'd1;
    drive(1'b0, 8'h00);
    tick();
    tick();
    n_vec++;
    if (ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL release_early: got ready %b after 2 edges want 0", ready_o);
    end
    tick();
    n_vec++;
    if ({ready_o, full_o, wr_count_o} !== {1'b1, 1'b0, 4'd7}) begin
      n_err++;
      $display("FAIL release: got ready %b full %b count %0d want 1 0 7", ready_o, full_o, wr_count_o);
    end
    drive(1'b1, 8'h55);
    #1;
    n_vec++;
    if ({wr_valid_o, wr_addr_o} !== {1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL release_push: got wr_valid %b addr %0d want 1 0", wr_valid_o, wr_addr_o);
    end
    tick();
    n_vec++;
    if (full_o !== 1'b1) begin
      n_err++;
      $display("FAIL refull: got full %b want 1", full_o);
    end
  endtask

  task automatic test_wrap();
    logic [PW-1:0] prev_gray;
    logic [PW-1:0] diff;
    logic [AW-1:0] exp_addr;
    int            accepted;
    logic          saw_wrap;
    prev_gray = wptr_gray_o;
    exp_addr  = 3'd1;
    accepted  = 0;
    saw_wrap  = 1'b0;
    for (int c = 0; c < 200 && accepted < 20; c++) begin
      diff = m_wbin - rd_bin;
      if (diff > 4'd4) rd_bin = rd_bin + 4'd1;
      drive(1'b1, 8'(c) ^ 8'h3C);
      #1;
      if (!m_full) begin
        n_vec++;
        if (wr_addr_o !== exp_addr) begin
          n_err++;
          $display("FAIL wrap_addr: got %0d want %0d", wr_addr_o, exp_addr);
        end
        exp_addr = exp_addr + 3'd1;
        accepted++;
      end
      tick();
      n_vec++;
      if ($countones(wptr_gray_o ^ prev_gray) > 1) begin
        n_err++;
        $display("FAIL gray_step: got %b after %b want single-bit change", wptr_gray_o, prev_gray);
      end
      if (prev_gray == 4'b1000 && wptr_gray_o == 4'b0000) saw_wrap = 1'b1;
      prev_gray = wptr_gray_o;
    end
    n_vec++;
    if (accepted != 20) begin
      n_err++;
      $display("FAIL wrap_timeout: got %0d pushes want 20", accepted);
    end
    n_vec++;
    if (saw_wrap !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_seen: got %b want 1", saw_wrap);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      if (rd_bin != m_wbin && $urandom_range(1, 0) == 1) rd_bin = rd_bin + 4'd1;
      drive(1'($urandom_range(1, 0)), 8'($urandom));
      tick();
    end
    drive(1'b0, 8'h00);
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_reset_mid();
    rd_bin = '0;
    drive(1'b0, 8'h00);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'hC0 + 8'(i));
      tick();
    end
    drive(1'b1, 8'hC5);
    #1;
    n_vec++;
    if ({wr_valid_o, wr_addr_o, wr_count_o} !== {1'b1, 3'd5, 4'd5}) begin
      n_err++;
      $display("FAIL mid_pre: got wr_valid %b addr %0d count %0d want 1 5 5", wr_valid_o, wr_addr_o, wr_count_o);
    end
    #1 reset_i = 1'b1;
    #1;
    n_vec++;
    if ({wr_valid_o, ready_o, full_o, wptr_gray_o, wr_count_o} !== {3'b000, 4'h0, 4'h0}) begin
      n_err++;
      $display("FAIL mid_async: got wr_valid %b ready %b full %b gray %h count %0d want 0 0 0 0 0",
               wr_valid_o, ready_o, full_o, wptr_gray_o, wr_count_o);
    end
    tick();
    reset_i = 1'b0;
    drive(1'b1, 8'h77);
    #1;
    n_vec++;
    if ({wr_valid_o, wr_addr_o, wptr_gray_o, wr_count_o} !== {1'b1, 3'd0, 4'h0, 4'h0}) begin
      n_err++;
      $display("FAIL mid_first: got wr_valid %b addr %0d gray %h count %0d want 1 0 0 0",
               wr_valid_o, wr_addr_o, wptr_gray_o, wr_count_o);
    end
    tick();
    drive(1'b0, 8'h00);
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_release();
    test_wrap();
    test_random();
    test_reset_mid();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending writes want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1);
  end

endmodule

// File: doc/fifo_cdc_wr_ctrl.md
FIFO_CDC_WR_CTRL -- requirements
Module: fifo_cdc_wr_ctrl

Interface
REQ-001 SHALL have parameter width_p, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter depth_p, default 8, meaning RAM entries; power of two, at least 2; AW = $clog2(depth_p).
REQ-003 SHALL have clk_i input 1 bit, the single write-domain clock; all state is on posedge clk_i.
REQ-004 SHALL have reset_i input 1 bit, asynchronous active-high reset.
REQ-005 SHALL have valid_i input 1 bit, meaning the upstream producer offers data_i.
REQ-006 SHALL have data_i input width_p bits, meaning the upstream write data.
REQ-007 SHALL have ready_o output 1 bit, meaning the block accepts data this cycle.
REQ-008 SHALL have wr_valid_o output 1 bit, the RAM write enable.
REQ-009 SHALL have wr_addr_o output AW bits, the RAM write address.
REQ-010 SHALL have wr_data_o output width_p bits, the RAM write data.
REQ-011 SHALL have wptr_gray_o output AW+1 bits, the registered Gray write pointer sent to the read domain.
REQ-012 SHALL have rptr_gray_i input AW+1 bits, the Gray read pointer from the read domain, asynchronous to clk_i.
REQ-013 SHALL have full_o output 1 bit, meaning the FIFO is full.
REQ-014 SHALL have wr_count_o output AW+1 bits, the conservative occupancy seen from the write domain.

Function
REQ-015 SHALL define push = valid_i & ready_o.
REQ-016 SHALL drive ready_o = ~full_r & ~reset_i.
REQ-017 SHALL drive wr_valid_o = push, wr_data_o = data_i (combinational pass-through), and wr_addr_o = wbin_r[AW-1:0].
REQ-018 SHALL keep an AW+1-bit binary pointer wbin_r that increments by 1 on push, with natural modulo 2^(AW+1) wrap.
REQ-019 SHALL register wptr_gray_o <= bin2gray(wbin_next) each cycle, so it changes by at most one bit per cycle.
REQ-020 SHALL synchronize rptr_gray_i through exactly two flops to give rsync; no other logic SHALL sit before the first flop.
REQ-021 SHALL register full_r <= (gray(wbin_next) == {~rsync[AW:AW-1], rsync[AW-2:0]}), with full_o = full_r; for AW=1 the whole pointer SHALL be inverted.
REQ-022 SHALL compute wr_count_o = wbin_r - gray2bin(rsync), modulo 2^(AW+1), with range 0..depth_p.
REQ-023 SHALL accept a write in the same cycle that full_r falls, and SHALL never produce a push while full_r = 1.
REQ-024 SHALL make full release 3 rising edges after rptr_gray_i changes (2 sync edges + 1 edge for full_r).
REQ-025 SHALL treat valid_i while ready_o = 0 as no-op; data_i need not be held, and there are no pointer or RAM side effects.

Reset
REQ-026 SHALL, on reset_i assertion, immediately clear wbin_r, wptr_gray_o, both sync flops, and full_r.
REQ-027 SHALL hold ready_o = 0 and wr_valid_o = 0 while reset_i = 1.
REQ-028 SHALL, on reset mid-operation, discard all in-flight state; the read side must be reset concurrently.
REQ-029 SHALL, after reset deassertion, give full_o = 0, wr_count_o = 0, wptr_gray_o = 0 and ready_o = 1 in the first cycle.

Structure
REQ-030 SHALL place the bin2gray and gray2bin functions in shared package fifo_cdc_pkg for reuse by the read-side controller.
REQ-031 SHALL implement the two-flop synchronizer as sub-module sync2 (parameter width_p, async active-high reset), reused by the read side.
REQ-032 SHALL contain no storage array; data storage remains in the external async-read RAM.

Verification
REQ-033 SHALL cover this scenario: depth_p = 8, rptr_gray_i held 0, valid_i = 1 continuous -> 8 pushes to addresses 0..7, full_o = 1 and ready_o = 0 after the 8th edge, wr_count_o = 8.
REQ-034 SHALL cover this scenario: from full, rptr_gray_i set to gray(1) = 1 -> ready_o = 1 after the 3rd edge, the next push writes address 0, then full again.
REQ-035 SHALL cover this scenario: 20 pushes with the reader tracking -> wbin wraps 15 to 0, wr_addr_o sequence 7 to 0, and every wptr_gray_o change is a single bit.
REQ-036 SHALL cover this scenario: reset_i pulsed asynchronously mid-burst (wbin_r = 5) -> outputs clear with no clock edge, wr_valid_o = 0 during reset, and the first post-reset push writes address 0.
REQ-037 SHALL cover this scenario: valid_i toggling randomly against a scoreboard RAM model -> data written in order, no write while full_o = 1, and wr_count_o never exceeds 8.
